// File: rtl/ofs_asp_mmio64_csr_responder.sv
// ofs_asp_mmio64_csr_responder
// Avalon-MM responder for 64-bit host MMIO in the pClk domain. It decodes
// host CSR accesses into a DFH header, AFU ID words, a scratch register,
// cycle and write counters, and a soft-reset control. Reads return with a
// fixed two-cycle latency and are fully pipelined. A write to CTRL bit 0
// starts a kernel soft-reset pulse.

module ofs_asp_mmio64_csr_responder #(
    parameter int unsigned ADDR_W          = 8,
    parameter logic [63:0] DFH_VALUE       = 64'h1000_0000_0000_1000,
    parameter logic [63:0] AFU_ID_L        = 64'h0,
    parameter logic [63:0] AFU_ID_H        = 64'h0,
    parameter int unsigned SOFT_RST_CYCLES = 16
) (
    input  logic              pClk,
    input  logic              pClk_reset,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [63:0]       avs_writedata,
    input  logic [7:0]        avs_byteenable,
    output logic              avs_waitrequest,
    output logic [63:0]       avs_readdata,
    output logic              avs_readdatavalid,
    output logic              soft_reset_out
);

    localparam int unsigned      CNT_W    = $clog2(SOFT_RST_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SOFT_RST_CYCLES);

    localparam logic [ADDR_W-1:0] REG_DFH     = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] REG_ID_L    = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] REG_ID_H    = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] REG_SCRATCH = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] REG_CYCLES  = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] REG_WRCOUNT = ADDR_W'(5);
    localparam logic [ADDR_W-1:0] REG_CTRL    = ADDR_W'(6);

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic              rd_acc;
    logic              wr_acc;
    logic              soft_trig;

    logic [63:0]       scratch;
    logic [63:0]       cycle_count;
    logic [31:0]       wr_count;
    logic [CNT_W-1:0]  rst_cnt;

    logic              rd_s1_valid;
    logic [ADDR_W-1:0] rd_s1_addr;
    logic [63:0]       rd_s1_cycles;
    logic [63:0]       rd_value;

    // Interface state register: stays in INIT through reset and one cycle after.
    always_ff @(posedge pClk) begin
        if (pClk_reset) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: INIT always advances to READY, READY is terminal.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:  state_d = ST_READY;
            ST_READY: state_d = ST_READY;
            default:  state_d = ST_INIT;
        endcase
    end

    assign avs_waitrequest = (state_q == ST_INIT);

    // A simultaneous read and write performs the write and drops the read.
    assign wr_acc    = avs_write & ~avs_waitrequest;
    assign rd_acc    = avs_read & ~avs_write & ~avs_waitrequest;
    assign soft_trig = wr_acc & (avs_address == REG_CTRL)
                     & avs_byteenable[0] & avs_writedata[0];

    // Scratch register with byte-lane masked writes.
    always_ff @(posedge pClk) begin
        if (pClk_reset) begin
            scratch <= '0;
        end else if (wr_acc && (avs_address == REG_SCRATCH)) begin
            for (int unsigned i = 0; i < 8; i++) begin
                if (avs_byteenable[i]) begin
                    scratch[i*8 +: 8] <= avs_writedata[i*8 +: 8];
                end
            end
        end
    end

    // Free-running 64-bit cycle counter since reset.
    always_ff @(posedge pClk) begin
        if (pClk_reset) begin
            cycle_count <= '0;
        end else begin
            cycle_count <= cycle_count + 64'd1;
        end
    end

    // Count of accepted writes to any address, 32-bit wrapping.
    always_ff @(posedge pClk) begin
        if (pClk_reset) begin
            wr_count <= '0;
        end else if (wr_acc) begin
            wr_count <= wr_count + 32'd1;
        end
    end

    // Soft-reset pulse timer: each trigger reloads the full length.
    always_ff @(posedge pClk) begin
        if (pClk_reset) begin
            rst_cnt <= '0;
        end else if (soft_trig) begin
            rst_cnt <= CNT_LOAD;
        end else if (rst_cnt != '0) begin
            rst_cnt <= rst_cnt - CNT_W'(1);
        end
    end

    assign soft_reset_out = (rst_cnt != '0);

    // Read stage 1: capture address and the cycle count of the accept cycle.
    always_ff @(posedge pClk) begin
        if (pClk_reset) begin
            rd_s1_valid  <= 1'b0;
            rd_s1_addr   <= '0;
            rd_s1_cycles <= '0;
        end else begin
            rd_s1_valid <= rd_acc;
            if (rd_acc) begin
                rd_s1_addr   <= avs_address;
                rd_s1_cycles <= cycle_count;
            end
        end
    end

    // Register-map decode for the read in stage 1.
    always_comb begin
        rd_value = '0;
        case (rd_s1_addr)
            REG_DFH:     rd_value = DFH_VALUE;
            REG_ID_L:    rd_value = AFU_ID_L;
            REG_ID_H:    rd_value = AFU_ID_H;
            REG_SCRATCH: rd_value = scratch;
            REG_CYCLES:  rd_value = rd_s1_cycles;
            REG_WRCOUNT: rd_value = {32'h0, wr_count};
            REG_CTRL:    rd_value = {62'h0, soft_reset_out, 1'b0};
            default:     rd_value = '0;
        endcase
    end

    // Read stage 2: registered response, one valid pulse per accepted read.
    always_ff @(posedge pClk) begin
        if (pClk_reset) begin
            avs_readdatavalid <= 1'b0;
            avs_readdata      <= '0;
        end else begin
            avs_readdatavalid <= rd_s1_valid;
            if (rd_s1_valid) begin
                avs_readdata <= rd_value;
            end
        end
    end

endmodule

// File: tb/tb_ofs_asp_mmio64_csr_responder.sv
// Testbench for ofs_asp_mmio64_csr_responder: directed stimulus, a
// cycle-indexed behavioural model with a due-cycle response queue, and a
// per-cycle compare process, plus literal checks of key results.

module tb_ofs_asp_mmio64_csr_responder;

    localparam int          SOFT = 16;
    localparam logic [63:0] DFH  = 64'h1000_0000_0000_1000;

    logic        pClk;
    logic        pClk_reset;
    logic [7:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [63:0] avs_writedata;
    logic [7:0]  avs_byteenable;
    logic        avs_waitrequest;
    logic [63:0] avs_readdata;
    logic        avs_readdatavalid;
    logic        soft_reset_out;

    ofs_asp_mmio64_csr_responder #(
        .ADDR_W          (8),
        .DFH_VALUE       (DFH),
        .AFU_ID_L        (64'h0),
        .AFU_ID_H        (64'h0),
        .SOFT_RST_CYCLES (SOFT)
    ) dut (
        .pClk              (pClk),
        .pClk_reset        (pClk_reset),
        .avs_address       (avs_address),
        .avs_read          (avs_read),
        .avs_write         (avs_write),
        .avs_writedata     (avs_writedata),
        .avs_byteenable    (avs_byteenable),
        .avs_waitrequest   (avs_waitrequest),
        .avs_readdata      (avs_readdata),
        .avs_readdatavalid (avs_readdatavalid),
        .soft_reset_out    (soft_reset_out)
    );

    initial pClk = 1'b0;
    always #5 pClk = ~pClk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int          due;
        logic [63:0] data;
    } resp_t;

    resp_t       resp_q[$];
    logic [63:0] got[$];
    int          cur        = 0;
    bit          seen_reset = 0;
    bit          exp_wait   = 1;
    bit          rd_zero    = 0;
    int          last_reset = 0;
    int          soft_until = -1;
    logic [63:0] m_scratch  = '0;
    logic [31:0] m_wr       = '0;

    function automatic logic [63:0] model_read(input logic [7:0] a, input int t);
        case (a)
            8'd0:    return DFH;
            8'd3:    return m_scratch;
            8'd4:    return 64'(t - last_reset - 1);
            8'd5:    return {32'h0, m_wr};
            8'd6:    return (t + 1 <= soft_until) ? 64'h2 : 64'h0;
            default: return 64'h0;
        endcase
    endfunction

    // Model update at each rising edge from the bench's own input values.
    always @(posedge pClk) begin
        if (pClk_reset) begin
            seen_reset = 1;
            exp_wait   = 1;
            rd_zero    = 1;
            resp_q.delete();
            m_scratch  = '0;
            m_wr       = '0;
            last_reset = cur;
            soft_until = cur;
        end else begin
            rd_zero = 0;
            if (!exp_wait && avs_write) begin
                m_wr = m_wr + 32'd1;
                if (avs_address == 8'd3) begin
                    for (int i = 0; i < 8; i++) begin
                        if (avs_byteenable[i]) m_scratch[i*8 +: 8] = avs_writedata[i*8 +: 8];
                    end
                end
                if (avs_address == 8'd6 && avs_byteenable[0] && avs_writedata[0])
                    soft_until = cur + SOFT;
            end else if (!exp_wait && avs_read) begin
                resp_q.push_back('{due: cur + 2, data: model_read(avs_address, cur)});
            end
            exp_wait = 0;
        end
        cur++;
    end

    // Per-cycle compare of all outputs against the model.
    always @(negedge pClk) begin : compare
        logic exp_rdv;
        if (seen_reset) begin
            exp_rdv = (resp_q.size() > 0) && (resp_q[0].due == cur);
            chk("waitrequest", 64'(avs_waitrequest), 64'(exp_wait));
            chk("readdatavalid", 64'(avs_readdatavalid), 64'(exp_rdv));
            chk("soft_reset_out", 64'(soft_reset_out), 64'(cur <= soft_until));
            if (exp_rdv) begin
                chk("readdata", avs_readdata, resp_q[0].data);
                void'(resp_q.pop_front());
            end else if (rd_zero) begin
                chk("readdata_reset", avs_readdata, 64'h0);
            end
            if (avs_readdatavalid === 1'b1) got.push_back(avs_readdata);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic rd, input logic wr, input logic [7:0] a,
                         input logic [63:0] d, input logic [7:0] be);
        avs_read       = rd;
        avs_write      = wr;
        avs_address    = a;
        avs_writedata  = d;
        avs_byteenable = be;
        @(negedge pClk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h0, 64'h0, 8'h0);
    endtask

    task automatic read_one(input logic [7:0] a, output logic [63:0] d);
        got.delete();
        drive(1'b1, 1'b0, a, 64'h0, 8'h0);
        idle(3);
        chk("resp_count_single", 64'(got.size()), 64'd1);
        d = (got.size() > 0) ? got.pop_front() : 64'hx;
    endtask

    task automatic reset_and_wait();
        pClk_reset = 1'b1;
        idle(2);
        pClk_reset = 1'b0;
        idle(1);
    endtask

    logic [63:0] d;
    int          hi;

    initial begin
        pClk_reset     = 1'b1;
        avs_read       = 1'b0;
        avs_write      = 1'b0;
        avs_address    = '0;
        avs_writedata  = '0;
        avs_byteenable = '0;
        repeat (3) @(negedge pClk);
        pClk_reset = 1'b0;
        chk("wait_first_cycle", 64'(avs_waitrequest), 64'd1);
        chk("rdv_after_reset", 64'(avs_readdatavalid), 64'd0);
        chk("soft_after_reset", 64'(soft_reset_out), 64'd0);
        idle(1);
        chk("wait_ready", 64'(avs_waitrequest), 64'd0);

        read_one(8'd0, d);
        chk("dfh", d, 64'h1000_0000_0000_1000);

        // Byte-masked scratch write, then two back-to-back reads.
        drive(1'b0, 1'b1, 8'd3, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
        got.delete();
        drive(1'b1, 1'b0, 8'd3, 64'h0, 8'h0);
        drive(1'b1, 1'b0, 8'd3, 64'h0, 8'h0);
        idle(4);
        chk("scratch_resp_count", 64'(got.size()), 64'd2);
        chk("scratch_be_1", (got.size() > 0) ? got[0] : 64'hx, 64'h0000_0000_FFFF_FFFF);
        chk("scratch_be_2", (got.size() > 1) ? got[1] : 64'hx, 64'h0000_0000_FFFF_FFFF);

        read_one(8'd4, d);

        // Pipelined burst of reads.
        got.delete();
        drive(1'b1, 1'b0, 8'd0, 64'h0, 8'h0);
        drive(1'b1, 1'b0, 8'd1, 64'h0, 8'h0);
        drive(1'b1, 1'b0, 8'd2, 64'h0, 8'h0);
        drive(1'b1, 1'b0, 8'd3, 64'h0, 8'h0);
        drive(1'b1, 1'b0, 8'd7, 64'h0, 8'h0);
        idle(4);
        chk("burst_count", 64'(got.size()), 64'd5);
        chk("burst_dfh", (got.size() > 0) ? got[0] : 64'hx, DFH);
        chk("burst_idl", (got.size() > 1) ? got[1] : 64'hx, 64'h0);
        chk("burst_idh", (got.size() > 2) ? got[2] : 64'hx, 64'h0);
        chk("burst_scratch", (got.size() > 3) ? got[3] : 64'hx, 64'h0000_0000_FFFF_FFFF);
        chk("burst_unmapped", (got.size() > 4) ? got[4] : 64'hx, 64'h0);

        // Soft reset with a retrigger at N+5; CTRL read during the pulse.
        got.delete();
        hi = 0;
        drive(1'b0, 1'b1, 8'd6, 64'h1, 8'h01);
        for (int k = 1; k <= 30; k++) begin
            if (soft_reset_out === 1'b1) hi++;
            if (k == 5)      drive(1'b0, 1'b1, 8'd6, 64'h1, 8'h01);
            else if (k == 8) drive(1'b1, 1'b0, 8'd6, 64'h0, 8'h0);
            else             idle(1);
        end
        chk("soft_pulse_len", 64'(hi), 64'd21);
        chk("ctrl_read_during_pulse", (got.size() > 0) ? got[0] : 64'hx, 64'h2);

        // Write counter, including an unmapped address.
        reset_and_wait();
        drive(1'b0, 1'b1, 8'd3, 64'h12, 8'hFF);
        drive(1'b0, 1'b1, 8'd0, 64'h34, 8'hFF);
        drive(1'b0, 1'b1, 8'd9, 64'h56, 8'hFF);
        read_one(8'd5, d);
        chk("wrcount_3", d, 64'd3);

        // Wrap of the write counter from all-ones.
        force dut.wr_count = 32'hFFFF_FFFF;
        m_wr = 32'hFFFF_FFFF;
        idle(1);
        release dut.wr_count;
        drive(1'b0, 1'b1, 8'd9, 64'h0, 8'hFF);
        read_one(8'd5, d);
        chk("wrcount_wrap", d, 64'd0);

        // Reset right after a read drops its response.
        got.delete();
        drive(1'b1, 1'b0, 8'd0, 64'h0, 8'h0);
        pClk_reset = 1'b1;
        idle(2);
        pClk_reset = 1'b0;
        idle(4);
        chk("abort_no_resp", 64'(got.size()), 64'd0);

        // Simultaneous read and write: write wins, no response.
        got.delete();
        drive(1'b1, 1'b1, 8'd3, 64'hA5, 8'hFF);
        idle(4);
        chk("rw_no_resp", 64'(got.size()), 64'd0);
        read_one(8'd3, d);
        chk("rw_scratch", d, 64'hA5);

        idle(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
